// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped down-counter timer:
// FSM encodings, register offsets, CTRL bit positions and mode codes.
package timer_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } timer_state_t;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;

   localparam int EN      = 0;
   localparam int MODE_LO = 1;
   localparam int MODE_HI = 2;
   localparam int IM      = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/mmio_timer.sv
// Programmable down-counter timer on the CPU data-memory bus with a level
// interrupt toward CP0. The FSM state is exported on state_dbg.
module mmio_timer
   import timer_defs::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       addr,
   input  logic             we,
   input  logic [CNT_W-1:0] din,
   output logic [CNT_W-1:0] dout,
   output logic             irq,
   output logic [1:0]       state_dbg
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   timer_state_t     state, state_n;
   logic [3:0]       ctrl, ctrl_n;
   logic [CNT_W-1:0] preset, preset_n;
   logic [CNT_W-1:0] count, count_n;
   logic             irq_pend, irq_pend_n;
   logic             pend_set, pend_clr;
   logic             ctrl_wr;

   assign ctrl_wr = we && (addr == OFF_CTRL);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ctrl     <= 4'h0;
         preset   <= '0;
         count    <= '0;
         irq_pend <= 1'b0;
      end else begin
         state    <= state_n;
         ctrl     <= ctrl_n;
         preset   <= preset_n;
         count    <= count_n;
         irq_pend <= irq_pend_n;
      end
   end

   always_comb begin
      state_n    = state;
      ctrl_n     = ctrl;
      preset_n   = preset;
      count_n    = count;
      irq_pend_n = irq_pend;
      pend_set   = 1'b0;
      pend_clr   = 1'b0;

      case (state)
         IDLE: if (ctrl[EN]) state_n = LOAD;
         LOAD: begin
            count_n = preset;
            state_n = CNT;
         end
         CNT: begin
            // COUNT of 0 or 1 both expire here, so PRESET=0 acts like PRESET=1
            if (ctrl[EN]) begin
               if (count > ONE) begin
                  count_n = count - ONE;
               end else begin
                  count_n  = '0;
                  pend_set = 1'b1;
                  state_n  = INT;
               end
            end
         end
         INT: begin
            if (ctrl[MODE_HI:MODE_LO] == MODE_RELOAD) begin
               pend_clr = 1'b1;
               state_n  = LOAD;
            end else begin
               ctrl_n[EN] = 1'b0;
               state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      // Bus writes are applied after the FSM so the CPU value wins for CTRL
      if (ctrl_wr) begin
         ctrl_n   = din[3:0];
         pend_clr = 1'b1;
      end
      if (we && (addr == OFF_PRESET)) preset_n = din;

      if (pend_set)      irq_pend_n = 1'b1;
      else if (pend_clr) irq_pend_n = 1'b0;
   end

   always_comb begin
      dout = '0;
      case (addr)
         OFF_CTRL:   dout = {{(CNT_W-4){1'b0}}, ctrl};
         OFF_PRESET: dout = preset;
         OFF_COUNT:  dout = count;
         default:    dout = '0;
      endcase
   end

   assign irq       = irq_pend & ctrl[IM];
   assign state_dbg = state;

endmodule
